// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix ALU datapath: op codes, element-count helpers
// and the result serializer state encoding.
package matrix_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_KRO = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

  // Elements produced by add/sub/mul: rows of A times columns of B.
  function automatic int ne_elem(input int a_rows, input int b_cols);
    return a_rows * b_cols;
  endfunction

  // Elements produced by the Kronecker product: both matrix sizes multiplied.
  function automatic int ne_full(input int a_rows, input int a_cols,
                                 input int b_rows, input int b_cols);
    return a_rows * a_cols * b_rows * b_cols;
  endfunction

endpackage

// File: rtl/matrix_result_serializer_if.sv
// Capture/stream bundle between the matrix ALU, the result serializer and its
// narrow consumer. The serializer takes the slave modport.
interface matrix_result_serializer_if
  import matrix_pkg::*;
#(
  parameter int word_size     = 8,
  parameter int Amatrixrownum = 2,
  parameter int Amatrixcolnum = 2,
  parameter int Bmatrixrownum = 2,
  parameter int Bmatrixcolnum = 2
) ();

  localparam int NE_FULL = ne_full(Amatrixrownum, Amatrixcolnum, Bmatrixrownum, Bmatrixcolnum);
  localparam int CW      = NE_FULL * word_size;
  localparam int IW      = ($clog2(NE_FULL) > 0) ? $clog2(NE_FULL) : 1;

  logic                 start;
  logic [1:0]           op;
  logic [CW-1:0]        C;
  logic                 busy;
  logic [word_size-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_index;
  logic                 out_last;

  modport master (
    output start, op, C, out_ready,
    input  busy, out_data, out_valid, out_index, out_last
  );

  modport slave (
    input  start, op, C, out_ready,
    output busy, out_data, out_valid, out_index, out_last
  );

endinterface

// File: rtl/matrix_result_serializer.sv
// Captures one wide matrix ALU result and streams its valid elements out one word
// per valid/ready transfer. Optional MATRIX_SER_DROP_CNT_EN adds a dropped-start counter.
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int word_size     = 8,
  parameter int Amatrixrownum = 2,
  parameter int Amatrixcolnum = 2,
  parameter int Bmatrixrownum = 2,
  parameter int Bmatrixcolnum = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  matrix_result_serializer_if.slave bus
`ifdef MATRIX_SER_DROP_CNT_EN
  ,
  output logic [7:0]                drop_cnt
`endif
);

  localparam int NE_FULL = ne_full(Amatrixrownum, Amatrixcolnum, Bmatrixrownum, Bmatrixcolnum);
  localparam int NE_ELEM = ne_elem(Amatrixrownum, Bmatrixcolnum);
  localparam int CW      = NE_FULL * word_size;
  localparam int IW      = ($clog2(NE_FULL) > 0) ? $clog2(NE_FULL) : 1;

  ser_state_e                          state_q;
  logic [NE_FULL-1:0][word_size-1:0]   cap_q;
  logic [IW-1:0]                       last_idx_q;
  logic                                busy_q;
  logic                                out_valid_q;
  logic                                out_last_q;
  logic [word_size-1:0]                out_data_q;
  logic [IW-1:0]                       out_index_q;

  logic [IW-1:0]                       last_idx_d;
  logic [IW-1:0]                       idx_inc_d;
  logic [word_size-1:0]                elem_next_d;

  // Count target for a new capture and the element that follows the current one.
  always_comb begin
    last_idx_d  = IW'(NE_ELEM - 1);
    idx_inc_d   = out_index_q + IW'(1);
    elem_next_d = cap_q[idx_inc_d];
    if (bus.op == OP_KRO) begin
      last_idx_d = IW'(NE_FULL - 1);
    end else begin
      last_idx_d = IW'(NE_ELEM - 1);
    end
  end

  // Capture/stream FSM; every output is a register so the consumer sees clean timing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cap_q       <= '0;
      last_idx_q  <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            cap_q       <= bus.C;
            last_idx_q  <= last_idx_d;
            state_q     <= ST_STREAM;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_index_q <= '0;
            out_data_q  <= bus.C[word_size-1:0];
            out_last_q  <= (last_idx_d == IW'(0));
          end
        end
        ST_STREAM: begin
          // Starts arriving here are ignored; cap_q only loads from IDLE.
          if (bus.out_ready) begin
            if (out_index_q == last_idx_q) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              out_index_q <= idx_inc_d;
              out_data_q  <= elem_next_d;
              out_last_q  <= (idx_inc_d == last_idx_q);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;

`ifdef MATRIX_SER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of starts that arrive while a result is still streaming.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt_q <= 8'd0;
    end else if (bus.start && (state_q == ST_STREAM) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
